// File: rtl/layer_priority_mux.sv
// N-layer pixel compositor: two-stage pipeline, frame-synchronous enables, colour key.
// Define LAYER_PRIORITY_MUX_COLLISION_EN to build per-frame collision reporting.
module layer_priority_mux #(
    parameter int unsigned        NUM_LAYERS      = 4,
    parameter int unsigned        COLOR_W         = 8,
    parameter logic [COLOR_W-1:0] TRANSPARENT_RGB = 8'hFF,
    localparam int unsigned       IDX_W           = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_LAYERS-1:0]         layer_req,
    input  logic [NUM_LAYERS*COLOR_W-1:0] layer_rgb,
    input  logic [COLOR_W-1:0]            background_rgb,
    input  logic                          start_of_frame,
    input  logic [NUM_LAYERS-1:0]         layer_en_next,
    output logic [COLOR_W-1:0]            rgb_out,
    output logic [IDX_W-1:0]              winner_idx,
    output logic                          winner_valid,
    output logic [NUM_LAYERS-1:0]         collision_flags,
    output logic                          collision_valid
);

    logic [NUM_LAYERS-1:0]         r_en_act;
    logic [NUM_LAYERS-1:0]         w_q;
    logic [NUM_LAYERS-1:0]         r_q1;
    logic [NUM_LAYERS*COLOR_W-1:0] r_rgb1;
    logic [COLOR_W-1:0]            r_bg1;

    logic                          w_win_valid;
    logic [IDX_W-1:0]              w_win_idx;
    logic [COLOR_W-1:0]            w_win_rgb;

    logic [COLOR_W-1:0]            r_rgb_out;
    logic [IDX_W-1:0]              r_winner_idx;
    logic                          r_winner_valid;

    always_comb begin
        for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
            w_q[i] = layer_req[i] & r_en_act[i] &
                     (layer_rgb[i*COLOR_W +: COLOR_W] != TRANSPARENT_RGB);
        end
    end

    // The start_of_frame cycle still qualifies with the old mask.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_en_act <= '1;
            r_q1     <= '0;
            r_rgb1   <= '0;
            r_bg1    <= '0;
        end else begin
            if (start_of_frame) begin
                r_en_act <= layer_en_next;
            end
            r_q1   <= w_q;
            r_rgb1 <= layer_rgb;
            r_bg1  <= background_rgb;
        end
    end

    always_comb begin
        w_win_valid = 1'b0;
        w_win_idx   = '0;
        w_win_rgb   = r_bg1;
        for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
            if (!w_win_valid && r_q1[i]) begin
                w_win_valid = 1'b1;
                w_win_idx   = IDX_W'(i);
                w_win_rgb   = r_rgb1[i*COLOR_W +: COLOR_W];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rgb_out      <= '0;
            r_winner_idx   <= '0;
            r_winner_valid <= 1'b0;
        end else begin
            r_rgb_out      <= w_win_rgb;
            r_winner_idx   <= w_win_idx;
            r_winner_valid <= w_win_valid;
        end
    end

    assign rgb_out      = r_rgb_out;
    assign winner_idx   = r_winner_idx;
    assign winner_valid = r_winner_valid;

`ifdef LAYER_PRIORITY_MUX_COLLISION_EN
    logic [NUM_LAYERS-1:0] w_contrib;
    logic [NUM_LAYERS-1:0] r_acc;
    logic [NUM_LAYERS-1:0] r_flags;
    logic                  r_cvalid;

    always_comb begin : contrib_calc
        logic [NUM_LAYERS-1:0] v_others;
        for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
            v_others     = r_q1;
            v_others[i]  = 1'b0;
            w_contrib[i] = r_q1[i] & (|v_others);
        end
    end

    // Stage-1 pixels present in the start_of_frame cycle close the old frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc    <= '0;
            r_flags  <= '0;
            r_cvalid <= 1'b0;
        end else begin
            r_cvalid <= start_of_frame;
            if (start_of_frame) begin
                r_flags <= r_acc | w_contrib;
                r_acc   <= '0;
            end else begin
                r_acc   <= r_acc | w_contrib;
            end
        end
    end

    assign collision_flags = r_flags;
    assign collision_valid = r_cvalid;
`else
    assign collision_flags = '0;
    assign collision_valid = 1'b0;
`endif

endmodule
